// File: rtl/if_stage.sv
// if_stage: MIPS instruction fetch stage; owns the PC and holds the fetched word.
// Define IF_JR_EN to let jr redirect the PC to rs_data (ignored otherwise).
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  OpCode,
    output logic [5:0]  Funct,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic [1:0]  Branch,
    input  logic        zero,
    input  logic [31:0] imm_ext,
    input  logic        jr,
    input  logic [31:0] rs_data,
    input  logic        exec_done
);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HOLD
    } state_t;

    state_t      state;
    logic [31:0] npc;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic [31:0] jr_tgt;
    logic        take_jr;
    logic        take_j;
    logic        take_br;
    logic        br_cond;
    logic        unused_bits;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign OpCode    = instr[31:26];
    assign Funct     = instr[5:0];

    // Branch offset drops the top two immediate bits before the wrap-around add.
    assign br_tgt = pc_plus4 + {imm_ext[29:0], 2'b00};
    assign j_tgt  = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign jr_tgt = {rs_data[31:2], 2'b00};

`ifdef IF_JR_EN
    assign take_jr     = jr;
    assign unused_bits = ^{imm_ext[31:30], rs_data[1:0]};
`else
    assign take_jr     = 1'b0;
    assign unused_bits = ^{imm_ext[31:30], jr, rs_data};
`endif

    assign br_cond = ((Branch == 2'b01) & zero) |
                     ((Branch == 2'b10) & ~zero);
    assign take_j  = ~take_jr & (Branch == 2'b11);
    assign take_br = ~take_jr & br_cond;

    always_comb begin
        npc = pc_plus4;
        unique case (1'b1)
            take_jr: npc = jr_tgt;
            take_j:  npc = j_tgt;
            take_br: npc = br_tgt;
            default: npc = pc_plus4;
        endcase
    end

    // imem_req is a register cleared by the async reset, so it drops at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
        end else begin
            unique case (state)
                BOOT: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ready) begin
                        instr       <= imem_rdata;
                        state       <= HOLD;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (exec_done) begin
                        pc          <= npc;
                        state       <= FETCH;
                        imem_req    <= 1'b1;
                        instr_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= BOOT;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed bench for if_stage with a per-cycle reference model.
// Honours IF_JR_EN the same way the design does.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic [5:0]  OpCode;
    logic [5:0]  Funct;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [1:0]  Branch = 2'b00;
    logic        zero = 1'b0;
    logic [31:0] imm_ext = 32'd0;
    logic        jr = 1'b0;
    logic [31:0] rs_data = 32'd0;
    logic        exec_done = 1'b0;

    int vecs = 0;
    int errs = 0;

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_rdata(imem_rdata),
        .instr(instr),
        .OpCode(OpCode),
        .Funct(Funct),
        .instr_valid(instr_valid),
        .pc(pc),
        .pc_plus4(pc_plus4),
        .Branch(Branch),
        .zero(zero),
        .imm_ext(imm_ext),
        .jr(jr),
        .rs_data(rs_data),
        .exec_done(exec_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: whether we are waiting on memory, holding a word,
    // or just out of reset, plus the architectural PC and held word.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_valid;
    logic        m_req;
    logic        m_boot;

    function automatic logic [31:0] model_npc(input logic [31:0] cur,
                                              input logic [31:0] word);
        logic [31:0] seq;
        seq = cur + 32'd4;
`ifdef IF_JR_EN
        if (jr) return rs_data & 32'hFFFF_FFFC;
`endif
        if (Branch == 2'b11) return {seq[31:28], word[25:0], 2'b00};
        if ((Branch == 2'b01 && zero) || (Branch == 2'b10 && !zero))
            return seq + imm_ext * 32'd4;
        return seq;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc    <= RST_PC;
            m_instr <= 32'd0;
            m_valid <= 1'b0;
            m_req   <= 1'b0;
            m_boot  <= 1'b1;
        end else if (m_boot) begin
            m_boot <= 1'b0;
            m_req  <= 1'b1;
        end else if (m_req) begin
            if (imem_ready) begin
                m_instr <= imem_rdata;
                m_req   <= 1'b0;
                m_valid <= 1'b1;
            end
        end else if (m_valid && exec_done) begin
            m_pc    <= model_npc(m_pc, m_instr);
            m_valid <= 1'b0;
            m_req   <= 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("instr", instr, m_instr);
        chk("opcode", {26'd0, OpCode}, {26'd0, m_instr[31:26]});
        chk("funct", {26'd0, Funct}, {26'd0, m_instr[5:0]});
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
        chk("imem_req", {31'd0, imem_req}, {31'd0, m_req});
        if (m_req) chk("imem_addr", imem_addr, m_pc);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic junk_inputs();
        Branch  = 2'b11;
        zero    = 1'b1;
        imm_ext = 32'h1234_5678;
        jr      = 1'b1;
        rs_data = 32'hDEAD_BEEF;
    endtask

    // Wait for a request, stall dly cycles (with a stray exec_done), then accept.
    task automatic fetch(input int dly, input logic [31:0] word);
        int n;
        n = 0;
        imem_ready = 1'b0;
        while (!imem_req && n < 8) begin
            step();
            n++;
        end
        chk("fetch_req_seen", {31'd0, imem_req}, 32'd1);
        imem_rdata = word;
        for (int i = 0; i < dly; i++) begin
            exec_done = 1'b1;
            step();
            chk("req_held", {31'd0, imem_req}, 32'd1);
        end
        exec_done  = 1'b0;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        imem_rdata = 32'hBAD0_BAD0;
        chk("valid_after_accept", {31'd0, instr_valid}, 32'd1);
        chk("instr_captured", instr, word);
    endtask

    task automatic exec(input logic [1:0] br, input logic z,
                        input logic [31:0] imm, input logic j,
                        input logic [31:0] rs);
        Branch     = br;
        zero       = z;
        imm_ext    = imm;
        jr         = j;
        rs_data    = rs;
        exec_done  = 1'b1;
        imem_ready = 1'b1;
        step();
        exec_done  = 1'b0;
        imem_ready = 1'b0;
        junk_inputs();
    endtask

    localparam logic [31:0] NOP_ADD = 32'h0000_0020;

    initial begin
        logic [31:0] imm;
        junk_inputs();
        imem_ready = 1'b1;
        #23;
        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_pc_plus4", pc_plus4, 32'h0000_3004);
        chk("rst_instr", instr, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_opcode", {26'd0, OpCode}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        imem_rdata = NOP_ADD;
        step();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0000_3000);
        chk("valid_before_accept", {31'd0, instr_valid}, 32'd0);
        step();
        imem_ready = 1'b0;
        chk("first_valid", {31'd0, instr_valid}, 32'd1);
        chk("first_instr", instr, NOP_ADD);
        chk("first_funct", {26'd0, Funct}, 32'h20);
        chk("first_pc", pc, 32'h0000_3000);
        exec(2'b00, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("seq_pc", pc, 32'h0000_3004);

        fetch(3, 32'h1000_FFFE);
        chk("beq_opcode", {26'd0, OpCode}, 32'h4);
        exec(2'b01, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'd0);
        chk("beq_taken", pc, 32'h0000_3000);
        fetch(0, NOP_ADD);
        exec(2'b00, 1'b0, 32'd0, 1'b0, 32'd0);
        fetch(0, 32'h1000_FFFE);
        exec(2'b01, 1'b0, 32'hFFFF_FFFE, 1'b0, 32'd0);
        chk("beq_not_taken", pc, 32'h0000_3008);
        fetch(0, NOP_ADD);
        exec(2'b01, 1'b1, 32'hFFFF_FFFD, 1'b0, 32'd0);
        chk("beq_back3", pc, 32'h0000_3000);
        fetch(0, NOP_ADD);
        exec(2'b00, 1'b0, 32'd0, 1'b0, 32'd0);
        fetch(1, 32'h1400_FFFE);
        exec(2'b10, 1'b0, 32'hFFFF_FFFE, 1'b0, 32'd0);
        chk("bne_taken", pc, 32'h0000_3000);

        for (int i = 0; i < 4; i++) begin
            fetch(0, NOP_ADD);
            exec(2'b00, 1'b0, 32'd0, 1'b0, 32'd0);
        end
        chk("seq_x4", pc, 32'h0000_3010);
        fetch(0, 32'h0800_0C10);
        exec(2'b11, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("jump", pc, 32'h0000_3040);

        fetch(0, 32'h03E0_0008);
        exec(2'b00, 1'b0, 32'd0, 1'b1, 32'h0000_3023);
`ifdef IF_JR_EN
        chk("jr", pc, 32'h0000_3020);
`else
        chk("jr_ignored", pc, 32'h0000_3044);
`endif

        imm = ((32'hFFFF_FFFC - (m_pc + 32'd4)) >> 2) | 32'hC000_0000;
        fetch(0, NOP_ADD);
        exec(2'b10, 1'b0, imm, 1'b0, 32'd0);
        chk("to_top", pc, 32'hFFFF_FFFC);
        chk("top_plus4_wraps", pc_plus4, 32'd0);
        fetch(0, NOP_ADD);
        exec(2'b00, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("wrap_pc", pc, 32'd0);
        fetch(0, NOP_ADD);
        exec(2'b10, 1'b1, 32'h0000_0100, 1'b0, 32'd0);
        chk("bne_not_taken", pc, 32'h0000_0004);
        fetch(0, NOP_ADD);
        exec(2'b01, 1'b1, (32'h0000_3050 - 32'd8) >> 2, 1'b0, 32'd0);
        chk("to_3050", pc, 32'h0000_3050);

        imem_ready = 1'b0;
        step();
        chk("mid_fetch_req", {31'd0, imem_req}, 32'd1);
        chk("mid_fetch_addr", imem_addr, 32'h0000_3050);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_drops_req", {31'd0, imem_req}, 32'd0);
        chk("reset_pc", pc, 32'h0000_3000);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("restart_req", {31'd0, imem_req}, 32'd1);
        chk("restart_addr", imem_addr, 32'h0000_3000);
        fetch(0, NOP_ADD);
        exec(2'b00, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("restart_seq", pc, 32'h0000_3004);
        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #100000;
        errs++;
        $display("FAIL watchdog: got timeout want finish");
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $fatal(1, "watchdog expired");
    end

endmodule
